// File: rtl/bh_io_unit.sv
// Byte-stream I/O unit for the brainhack core: an output FIFO fed by `.` and
// drained by the host, and an input FIFO filled by the host and drained by `,`.
`timescale 1ns/1ps
module bh_io_unit #(
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 16,
  parameter int                EOF_MODE  = 1,
  parameter logic [DATA_W-1:0] EOF_VALUE = '0
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_out_req,
  input  logic [DATA_W-1:0]           i_out_data,
  output logic                        o_out_stall,
  output logic                        o_host_out_valid,
  output logic [DATA_W-1:0]           o_host_out_data,
  input  logic                        i_host_out_ready,
  input  logic                        i_in_req,
  output logic [DATA_W-1:0]           o_in_data,
  output logic                        o_in_stall,
  input  logic                        i_host_in_valid,
  input  logic [DATA_W-1:0]           i_host_in_data,
  output logic                        o_host_in_ready,
  input  logic                        i_host_eof,
  output logic [$clog2(DEPTH):0]      o_out_count,
  output logic [$clog2(DEPTH):0]      o_in_count,
  output logic                        o_eof_hit
);

  localparam int              AW          = $clog2(DEPTH);
  localparam int              CW          = AW + 1;
  localparam logic [CW-1:0]   FULL_CNT    = CW'(DEPTH);
  localparam bit              EOF_RETURNS = (EOF_MODE != 0);

  logic [DATA_W-1:0] out_mem_q [DEPTH];
  logic [DATA_W-1:0] in_mem_q  [DEPTH];

  logic [AW-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [AW-1:0] in_rd_q,  in_rd_d,  in_wr_q,  in_wr_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d, in_cnt_q, in_cnt_d;
  logic          eof_hit_q, eof_hit_d;

  logic out_full, out_empty, out_push, out_pop;
  logic in_full,  in_empty,  in_push,  in_pop, in_eof;

  // Output queue: full/empty come from the registered count only.
  always_comb begin
    out_full  = (out_cnt_q == FULL_CNT);
    out_empty = (out_cnt_q == '0);
    out_push  = i_out_req & ~out_full;
    out_pop   = ~out_empty & i_host_out_ready;
    out_wr_d  = out_wr_q + AW'(out_push);
    out_rd_d  = out_rd_q + AW'(out_pop);
    out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
  end

  // Input queue: buffered words always win over the host EOF flag.
  always_comb begin
    in_full   = (in_cnt_q == FULL_CNT);
    in_empty  = (in_cnt_q == '0);
    in_push   = i_host_in_valid & ~in_full;
    in_pop    = i_in_req & ~in_empty;
    in_eof    = i_in_req & in_empty & i_host_eof;
    in_wr_d   = in_wr_q + AW'(in_push);
    in_rd_d   = in_rd_q + AW'(in_pop);
    in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(in_pop);
    eof_hit_d = eof_hit_q | in_eof;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      out_rd_q  <= '0;
      out_wr_q  <= '0;
      out_cnt_q <= '0;
      in_rd_q   <= '0;
      in_wr_q   <= '0;
      in_cnt_q  <= '0;
      eof_hit_q <= 1'b0;
    end else begin
      out_rd_q  <= out_rd_d;
      out_wr_q  <= out_wr_d;
      out_cnt_q <= out_cnt_d;
      in_rd_q   <= in_rd_d;
      in_wr_q   <= in_wr_d;
      in_cnt_q  <= in_cnt_d;
      eof_hit_q <= eof_hit_d;
    end
  end

  // Storage carries no reset; stale entries are never visible past the count.
  always_ff @(posedge i_clock) begin
    if (out_push) out_mem_q[out_wr_q] <= i_out_data;
    if (in_push)  in_mem_q[in_wr_q]   <= i_host_in_data;
  end

  assign o_out_stall      = i_out_req & out_full;
  assign o_host_out_valid = ~out_empty;
  assign o_host_out_data  = out_mem_q[out_rd_q];
  assign o_out_count      = out_cnt_q;

  assign o_host_in_ready  = ~in_full;
  assign o_in_stall       = i_in_req & in_empty & ~(i_host_eof & EOF_RETURNS);
  assign o_in_data        = in_empty ? EOF_VALUE : in_mem_q[in_rd_q];
  assign o_in_count       = in_cnt_q;
  assign o_eof_hit        = eof_hit_q;

endmodule

// File: tb/tb_bh_io_unit.sv
// Bench for bh_io_unit: table of input-path vectors, hand-written output and
// reset sequences, and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_bh_io_unit;

  localparam int DW = 8;
  localparam int D  = 4;
  localparam int NW = 3 * D + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  // Instance A: EOF_MODE=1, EOF_VALUE=0xFF
  logic          out_req = 0, out_ready = 0, in_req = 0, hv = 0, eof = 0;
  logic [DW-1:0] out_data = 0, hd = 0;
  logic          out_stall, out_valid, in_stall, in_ready, eof_hit;
  logic [DW-1:0] out_head, in_data;
  logic [2:0]    out_cnt, in_cnt;

  // Instance B: EOF_MODE=0
  logic          b_out_req = 0, b_out_ready = 0, b_in_req = 0, b_hv = 0, b_eof = 0;
  logic [DW-1:0] b_out_data = 0, b_hd = 0;
  logic          b_out_stall, b_out_valid, b_in_stall, b_in_ready, b_eof_hit;
  logic [DW-1:0] b_out_head, b_in_data;
  logic [2:0]    b_out_cnt, b_in_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bh_io_unit #(.DATA_W(DW), .DEPTH(D), .EOF_MODE(1), .EOF_VALUE(8'hFF)) u_dut (
    .i_clock(clk), .i_reset(rst),
    .i_out_req(out_req), .i_out_data(out_data), .o_out_stall(out_stall),
    .o_host_out_valid(out_valid), .o_host_out_data(out_head), .i_host_out_ready(out_ready),
    .i_in_req(in_req), .o_in_data(in_data), .o_in_stall(in_stall),
    .i_host_in_valid(hv), .i_host_in_data(hd), .o_host_in_ready(in_ready),
    .i_host_eof(eof), .o_out_count(out_cnt), .o_in_count(in_cnt), .o_eof_hit(eof_hit)
  );

  bh_io_unit #(.DATA_W(DW), .DEPTH(D), .EOF_MODE(0), .EOF_VALUE(8'hFF)) u_dut_b (
    .i_clock(clk), .i_reset(rst),
    .i_out_req(b_out_req), .i_out_data(b_out_data), .o_out_stall(b_out_stall),
    .o_host_out_valid(b_out_valid), .o_host_out_data(b_out_head), .i_host_out_ready(b_out_ready),
    .i_in_req(b_in_req), .o_in_data(b_in_data), .o_in_stall(b_in_stall),
    .i_host_in_valid(b_hv), .i_host_in_data(b_hd), .o_host_in_ready(b_in_ready),
    .i_host_eof(b_eof), .o_out_count(b_out_cnt), .o_in_count(b_in_cnt), .o_eof_hit(b_eof_hit)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          req;
    logic          hv;
    logic [DW-1:0] hd;
    logic          eof;
    logic          stall;
    logic [DW-1:0] data;
    logic          rdy;
    int            cnt;
    logic          hit;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic r, logic v, logic [DW-1:0] d, logic e,
                              logic s, logic [DW-1:0] x, logic y, int c, logic h);
    vec_t t;
    t.req = r; t.hv = v; t.hd = d; t.eof = e;
    t.stall = s; t.data = x; t.rdy = y; t.cnt = c; t.hit = h;
    return t;
  endfunction

  logic [DW-1:0] oq[$];
  logic [DW-1:0] iq[$];

  initial begin
    int pushed, popped;
    logic exp_push, exp_pop;
    logic [DW-1:0] seq[4];

    // req hv  hd     eof | stall data  rdy cnt hit
    tbl[0]  = mk(0, 1, 8'h48, 0,  0, 8'h00, 1, 1, 0);
    tbl[1]  = mk(0, 1, 8'h69, 0,  0, 8'h00, 1, 2, 0);
    tbl[2]  = mk(1, 0, 8'h00, 0,  0, 8'h48, 1, 1, 0);
    tbl[3]  = mk(1, 0, 8'h00, 0,  0, 8'h69, 1, 0, 0);
    tbl[4]  = mk(1, 0, 8'h00, 0,  1, 8'h00, 1, 0, 0);
    tbl[5]  = mk(1, 1, 8'h12, 0,  1, 8'h00, 1, 1, 0);
    tbl[6]  = mk(1, 0, 8'h00, 1,  0, 8'h12, 1, 0, 0);
    tbl[7]  = mk(1, 0, 8'h00, 1,  0, 8'hFF, 1, 0, 1);
    tbl[8]  = mk(0, 1, 8'hA1, 0,  0, 8'h00, 1, 1, 1);
    tbl[9]  = mk(0, 1, 8'hA2, 0,  0, 8'h00, 1, 2, 1);
    tbl[10] = mk(0, 1, 8'hA3, 0,  0, 8'h00, 1, 3, 1);
    tbl[11] = mk(0, 1, 8'hA4, 0,  0, 8'h00, 1, 4, 1);
    tbl[12] = mk(1, 1, 8'hA5, 0,  0, 8'hA1, 0, 3, 1);
    tbl[13] = mk(1, 0, 8'h00, 0,  0, 8'hA2, 1, 2, 1);
    tbl[14] = mk(1, 0, 8'h00, 0,  0, 8'hA3, 1, 1, 1);
    tbl[15] = mk(1, 0, 8'h00, 0,  0, 8'hA4, 1, 0, 1);

    // Reset / idle
    #12;
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_in_cnt", in_cnt, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_eof_hit", eof_hit, 0);
    chk("rst_out_stall", out_stall, 0);
    chk("rst_in_stall", in_stall, 0);
    @(negedge clk); rst = 1'b0;

    // EOF with EOF_MODE=0 stalls but still flags
    @(negedge clk); b_in_req = 1; b_eof = 1;
    #1 chk("b_eof_stall", b_in_stall, 1);
    @(posedge clk); #1;
    chk("b_eof_hit", b_eof_hit, 1);
    chk("b_eof_cnt", b_in_cnt, 0);
    @(negedge clk); b_in_req = 0; b_eof = 0;

    // Input path table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_req = tbl[i].req; hv = tbl[i].hv; hd = tbl[i].hd; eof = tbl[i].eof;
      #1;
      chk($sformatf("tbl%0d_stall", i), in_stall, tbl[i].stall);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].rdy);
      if (tbl[i].req && !tbl[i].stall)
        chk($sformatf("tbl%0d_data", i), in_data, tbl[i].data);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_cnt", i), in_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_hit", i), eof_hit, tbl[i].hit);
    end
    @(negedge clk); in_req = 0; hv = 0; eof = 0;

    // Output fill to full, stall, single pop, retry
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      out_req = 1; out_data = seq[i]; out_ready = 0;
      #1 chk($sformatf("fill%0d_stall", i), out_stall, 0);
      @(posedge clk); #1;
    end
    chk("fill_cnt", out_cnt, 4);
    chk("fill_head", out_head, 8'h11);
    @(negedge clk); out_req = 1; out_data = 8'h55; out_ready = 0;
    #1 chk("full_stall", out_stall, 1);
    @(posedge clk); #1 chk("full_cnt_hold", out_cnt, 4);
    @(negedge clk); out_ready = 1;
    #1 chk("full_pop_stall", out_stall, 1);
    @(posedge clk); #1;
    chk("full_pop_cnt", out_cnt, 3);
    chk("full_pop_head", out_head, 8'h22);
    @(negedge clk); out_ready = 0;
    #1 chk("retry_stall", out_stall, 0);
    @(posedge clk); #1 chk("retry_cnt", out_cnt, 4);
    @(negedge clk); out_req = 0; out_ready = 1;
    seq[0] = 8'h22; seq[1] = 8'h33; seq[2] = 8'h44; seq[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain%0d_valid", i), out_valid, 1);
      chk($sformatf("drain%0d_head", i), out_head, seq[i]);
      @(negedge clk);
    end
    chk("drain_empty", out_valid, 0);
    out_ready = 0;

    // Randomized concurrent traffic on both queues
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 2000 && popped < NW; cyc++) begin
      @(negedge clk);
      out_req   = (pushed < NW) && ($urandom_range(0, 1) == 1);
      out_data  = DW'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      in_req    = ($urandom_range(0, 1) == 1);
      hv        = ($urandom_range(0, 1) == 1);
      hd        = DW'($urandom);
      eof       = 0;
      #1;
      chk("rnd_out_stall", out_stall, out_req && oq.size() == D);
      chk("rnd_out_valid", out_valid, oq.size() != 0);
      chk("rnd_out_cnt", out_cnt, oq.size());
      if (oq.size() != 0) chk("rnd_out_head", out_head, oq[0]);
      chk("rnd_in_stall", in_stall, in_req && iq.size() == 0);
      chk("rnd_in_ready", in_ready, iq.size() < D);
      chk("rnd_in_cnt", in_cnt, iq.size());
      if (in_req && iq.size() != 0) chk("rnd_in_data", in_data, iq[0]);
      exp_pop  = (oq.size() != 0) && out_ready;
      exp_push = out_req && (oq.size() < D);
      if (exp_pop) begin void'(oq.pop_front()); popped++; end
      if (exp_push) begin oq.push_back(out_data); pushed++; end
      exp_pop  = in_req && (iq.size() != 0);
      exp_push = hv && (iq.size() < D);
      if (exp_pop) void'(iq.pop_front());
      if (exp_push) iq.push_back(hd);
      @(posedge clk);
    end
    chk("rnd_all_drained", popped, NW);
    @(negedge clk); out_req = 0; out_ready = 0; in_req = 0; hv = 0;

    // Reset mid-stream
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); out_req = 1; out_data = seq[i];
      @(posedge clk); #1;
    end
    chk("pre_rst_cnt", out_cnt, 3);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_cnt", out_cnt, 0);
    chk("async_rst_in_cnt", in_cnt, 0);
    chk("async_rst_hit", eof_hit, 0);
    rst = 0;
    @(negedge clk); out_req = 1; out_data = 8'h5A;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_head", out_head, 8'h5A);
    chk("post_rst_cnt", out_cnt, 1);
    @(negedge clk); out_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
